saradc_sar_logic: RTL and testbench
===================================

Name: saradc_sar_logic

Overview:
- Digital SAR controller: the digital end of the SARADC analog macro's control interface.
- Drives SAMPLE, VALID, RESULTP and RESULTN into the analog macro and consumes its comparator output CMPO, resolving one bit per clock, MSB first.
- Holds each finished code in a one-entry output buffer with a valid/ready handshake.
- Sits between the analog macro and the system bus logic; runs on the macro's buffered clock.

Parameters:
- NBITS, 8, converter resolution; width of RESULTP, RESULTN and DOUT.
- NSAMPLE, 2, number of cycles SAMPLE is held high (track phase); legal range 1..15.

Ports:
- CLK  input  1  system clock (CLKBUF from the analog macro); all logic on rising edge.
- RSTN  input  1  synchronous reset, active-low.
- START  input  1  request one conversion; sampled only in IDLE.
- CONT  input  1  continuous mode: restart automatically after DONE.
- CMPO  input  1  comparator decision; 1 = positive side higher; sampled on the rising edge in CONV.
- SAMPLE  output  1  track/hold control to the analog macro.
- VALID  output  1  one-cycle pulse to the analog macro: conversion finished.
- RESULTP  output  NBITS  CDAC high-side switch controls; the analog macro consumes bits NBITS-1..1.
- RESULTN  output  NBITS  CDAC low-side switch controls.
- BUSY  output  1  high in every state except IDLE.
- DOUT  output  NBITS  last completed code.
- DOUT_VALID  output  1  DOUT holds an unread code.
- DOUT_READY  input  1  consumer accepts DOUT when DOUT_VALID && DOUT_READY.
- OVR  output  1  sticky overrun flag.
- CLR_OVR  input  1  clears OVR.

Behaviour:
- Reset (RSTN=0 at an edge): state=IDLE and all outputs 0. This includes RESULTP, RESULTN, DOUT, DOUT_VALID and OVR. Reset overrides everything, including mid-conversion; no partial result is ever published.
- States are IDLE, SAMP, CONV, DONE.
- IDLE:
  - START=1 at an edge -> SAMP.
  - RESULTP/RESULTN are cleared to 0 at that same edge.
- SAMP:
  - SAMPLE=1 for exactly NSAMPLE cycles, counted by a 4-bit counter.
  - At the NSAMPLE-th edge -> CONV, with bit index k=NBITS-1.
- CONV, one edge per bit:
  - RESULTP[k] <= CMPO and RESULTN[k] <= ~CMPO; unresolved bits stay 0/0.
  - This is monotonic top-plate switching: a resolved bit is never rewritten within a conversion.
  - The index decrements each edge. The edge with k=0 -> DONE.
- DONE, exactly one cycle:
  - VALID=1.
  - RESULTP holds the final code, RESULTN its complement.
  - Next state is SAMP if CONT=1, otherwise IDLE.
- RESULTP/RESULTN keep the final code through IDLE until the next SAMP entry.
- Output buffer:
  - At the CONV k=0 edge: DOUT <= {RESULTP[NBITS-1:1], CMPO} and DOUT_VALID <= 1.
  - DOUT_VALID clears at an edge where DOUT_READY=1 and no new code is loaded that edge.
- Overrun:
  - If DOUT_VALID=1 and not being accepted at the load edge, the new code overwrites DOUT and OVR <= 1.
  - A load that coincides with a handshake is not an overrun.
- OVR is sticky. CLR_OVR=1 clears it, except when an overrun occurs at the same edge; set wins.
- Latency: with START seen at edge E0, DOUT_VALID and VALID go high in the cycle after edge E(NSAMPLE+NBITS). For NSAMPLE=2, NBITS=8 this is the cycle after E10.
- Throughput in CONT mode: one code per NSAMPLE+NBITS+1 cycles.
- START while BUSY=1 is ignored; no queuing.
- CONT dropped mid-conversion: the current conversion completes, then the block goes to IDLE.
- CONT is sampled only in DONE; START is not required while CONT=1 after the first start.
- BUSY = (state != IDLE).
- SAMPLE=1 only in SAMP; VALID=1 only in DONE. The two are never simultaneously high.

Test Plan:
- Single conversion, NBITS=8, NSAMPLE=2, CMPO sequence 1,0,1,1,0,0,1,0 over CONV edges -> SAMPLE high 2 cycles; RESULTP builds 0x80,0x80,0xA0,0xB0,... to 0xB2; RESULTN=0x4D in DONE; DOUT=0xB2; VALID one cycle after E10; BUSY low after DONE.
- Backpressure: DOUT_READY=0, CONT=1, CMPO constant 1 -> first DOUT=0xFF; the second load sets OVR=1 and DOUT=0xFF; pulsing CLR_OVR clears OVR; DOUT_READY=1 drops DOUT_VALID the next edge.
- Simultaneous accept and load: DOUT_READY=1 at the load edge of the second conversion -> DOUT_VALID stays 1 and OVR stays 0.
- Reset mid-CONV after 4 bits -> all outputs 0 and state IDLE next cycle; DOUT_VALID never rises; a new START then gives a normal 11-cycle latency.
- START pulses during SAMP and CONV -> ignored; exactly one DONE/VALID pulse.
- Continuous mode with CMPO=0 -> codes 0x00 every 11 cycles; CONT deasserted during CONV -> finishes that code, returns to IDLE, BUSY=0.

Source files
------------

// File: rtl/saradc_sar_logic.sv
// ============================================================================
// saradc_sar_logic: SAR conversion FSM (MSB first) with a one-entry output buffer.
// Rev 1.0
// ============================================================================
`default_nettype none

module saradc_sar_logic #(
  parameter int NBITS   = 8,
  parameter int NSAMPLE = 2
) (
  input  logic             CLK,
  input  logic             RSTN,
  input  logic             START,
  input  logic             CONT,
  input  logic             CMPO,
  output logic             SAMPLE,
  output logic             VALID,
  output logic [NBITS-1:0] RESULTP,
  output logic [NBITS-1:0] RESULTN,
  output logic             BUSY,
  output logic [NBITS-1:0] DOUT,
  output logic             DOUT_VALID,
  input  logic             DOUT_READY,
  output logic             OVR,
  input  logic             CLR_OVR
);

  localparam int              KW          = (NBITS > 1) ? $clog2(NBITS) : 1;
  localparam logic [KW-1:0]   c_K_MSB     = KW'(NBITS - 1);
  localparam logic [3:0]      c_SAMP_LAST = 4'(NSAMPLE - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SAMP = 2'd1,
    S_CONV = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           r_state;
  logic [3:0]       r_cnt;
  logic [KW-1:0]    r_k;
  logic             r_sample;
  logic             r_valid;
  logic             r_busy;
  logic [NBITS-1:0] r_resp;
  logic [NBITS-1:0] r_resn;
  logic [NBITS-1:0] r_dout;
  logic             r_dout_valid;
  logic             r_ovr;

  logic             w_load;
  logic             w_ovr_set;
  logic [NBITS-1:0] w_code;

  // The LSB comes straight from the comparator so the code is published at the last CONV edge.
  assign w_load    = (r_state == S_CONV) && (r_k == '0);
  assign w_code    = {r_resp[NBITS-1:1], CMPO};
  assign w_ovr_set = w_load && r_dout_valid && !DOUT_READY;

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_k      <= '0;
      r_sample <= 1'b0;
      r_valid  <= 1'b0;
      r_busy   <= 1'b0;
      r_resp   <= '0;
      r_resn   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (START) begin
            r_state  <= S_SAMP;
            r_cnt    <= '0;
            r_sample <= 1'b1;
            r_busy   <= 1'b1;
            r_resp   <= '0;
            r_resn   <= '0;
          end
        end
        S_SAMP: begin
          if (r_cnt == c_SAMP_LAST) begin
            r_state  <= S_CONV;
            r_sample <= 1'b0;
            r_k      <= c_K_MSB;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        S_CONV: begin
          // Each bit is written once per conversion; unresolved bits stay 0/0.
          r_resp[r_k] <= CMPO;
          r_resn[r_k] <= ~CMPO;
          if (r_k == '0) begin
            r_state <= S_DONE;
            r_valid <= 1'b1;
          end else begin
            r_k <= r_k - KW'(1);
          end
        end
        S_DONE: begin
          r_valid <= 1'b0;
          if (CONT) begin
            r_state  <= S_SAMP;
            r_cnt    <= '0;
            r_sample <= 1'b1;
            r_resp   <= '0;
            r_resn   <= '0;
          end else begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state  <= S_IDLE;
          r_sample <= 1'b0;
          r_valid  <= 1'b0;
          r_busy   <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
      r_ovr        <= 1'b0;
    end else begin
      if (w_load) begin
        r_dout       <= w_code;
        r_dout_valid <= 1'b1;
      end else if (DOUT_READY) begin
        r_dout_valid <= 1'b0;
      end
      // A new overrun takes priority over a clear request in the same cycle.
      if (w_ovr_set) begin
        r_ovr <= 1'b1;
      end else if (CLR_OVR) begin
        r_ovr <= 1'b0;
      end
    end
  end

  assign SAMPLE     = r_sample;
  assign VALID      = r_valid;
  assign BUSY       = r_busy;
  assign RESULTP    = r_resp;
  assign RESULTN    = r_resn;
  assign DOUT       = r_dout;
  assign DOUT_VALID = r_dout_valid;
  assign OVR        = r_ovr;

endmodule

`default_nettype wire

// File: tb/tb_saradc_sar_logic.sv
// ============================================================================
// tb_saradc_sar_logic: vector table plus scoreboard of published codes.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_saradc_sar_logic;

  logic       CLK = 1'b0;
  logic       RSTN = 1'b0;
  logic       START = 1'b0;
  logic       CONT = 1'b0;
  logic       CMPO = 1'b0;
  logic       SAMPLE, VALID, BUSY, DOUT_VALID, OVR;
  logic [7:0] RESULTP, RESULTN, DOUT;
  logic       DOUT_READY = 1'b1;
  logic       CLR_OVR = 1'b0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_valid = 0;
  logic [7:0] sb_q[$];

  typedef struct {
    logic [7:0] seq;
    logic [7:0] exp_p;
    logic [7:0] exp_n;
  } vec_t;
  vec_t vecs[5];

  saradc_sar_logic #(.NBITS(8), .NSAMPLE(2)) dut (
    .CLK(CLK), .RSTN(RSTN), .START(START), .CONT(CONT), .CMPO(CMPO),
    .SAMPLE(SAMPLE), .VALID(VALID), .RESULTP(RESULTP), .RESULTN(RESULTN),
    .BUSY(BUSY), .DOUT(DOUT), .DOUT_VALID(DOUT_VALID), .DOUT_READY(DOUT_READY),
    .OVR(OVR), .CLR_OVR(CLR_OVR)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard: every DONE cycle must match the oldest expected code.
  always @(negedge CLK) begin
    logic [7:0] e;
    logic [7:0] en;
    if (VALID) begin
      n_valid++;
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: got VALID=1 expected no conversion (cycle %0d)", cyc);
      end else begin
        e  = sb_q.pop_front();
        en = ~e;
        check("sb_dout", DOUT, e);
        check("sb_resultp", RESULTP, e);
        check("sb_resultn", RESULTN, en);
        check("sb_dout_valid", DOUT_VALID, 1);
        check("sb_sample_excl", SAMPLE, 0);
      end
    end
  end

  task automatic wait_valid();
    bit seen = 1'b0;
    for (int n = 0; n < 40 && !seen; n++) begin
      @(negedge CLK);
      if (VALID) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL wait_valid: got no VALID expected one within 40 cycles");
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_sample"}, SAMPLE, 0);
    check({tag, "_valid"}, VALID, 0);
    check({tag, "_busy"}, BUSY, 0);
    check({tag, "_resultp"}, RESULTP, 0);
    check({tag, "_resultn"}, RESULTN, 0);
    check({tag, "_dout"}, DOUT, 0);
    check({tag, "_dout_valid"}, DOUT_VALID, 0);
    check({tag, "_ovr"}, OVR, 0);
  endtask

  // One conversion with CONT=0; noisy keeps START high through SAMP and CONV.
  task automatic do_conv(input logic [7:0] seq, input bit noisy);
    logic [7:0] mask;
    logic [7:0] nseq;
    nseq = ~seq;
    @(negedge CLK); START = 1'b1;
    @(posedge CLK);
    @(negedge CLK); START = noisy;
    check("samp_c1", SAMPLE, 1);
    check("busy_samp", BUSY, 1);
    check("resultp_cleared", RESULTP, 0);
    @(posedge CLK); @(negedge CLK);
    check("samp_c2", SAMPLE, 1);
    @(posedge CLK); @(negedge CLK);
    check("samp_off_conv", SAMPLE, 0);
    CMPO = seq[7];
    for (int i = 7; i >= 0; i--) begin
      @(posedge CLK); @(negedge CLK);
      mask = 8'hFF << i;
      check("resultp_prog", RESULTP, seq & mask);
      check("resultn_prog", RESULTN, nseq & mask);
      if (i > 0) CMPO = seq[i-1];
    end
    check("valid_latency", VALID, 1);
    START = 1'b0;
    @(posedge CLK); @(negedge CLK);
    check("valid_pulse_end", VALID, 0);
    check("busy_after_done", BUSY, 0);
    check("resultp_hold", RESULTP, seq);
  endtask

  initial begin
    int t1, t2, t3, nv0;
    vecs[0] = '{8'hB2, 8'hB2, 8'h4D};
    vecs[1] = '{8'h00, 8'h00, 8'hFF};
    vecs[2] = '{8'hFF, 8'hFF, 8'h00};
    vecs[3] = '{8'h5A, 8'h5A, 8'hA5};
    vecs[4] = '{8'h81, 8'h81, 8'h7E};

    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check_all_zero("reset");
    RSTN = 1'b1;

    // Table-driven single conversions.
    for (int v = 0; v < 5; v++) begin
      sb_q.push_back(vecs[v].exp_p);
      do_conv(vecs[v].seq, 1'b0);
      check("tbl_resultp", RESULTP, vecs[v].exp_p);
      check("tbl_resultn", RESULTN, vecs[v].exp_n);
      check("tbl_dout", DOUT, vecs[v].exp_p);
      check("tbl_dout_valid_clr", DOUT_VALID, 0);
    end

    // Backpressure and overrun.
    DOUT_READY = 1'b0; CONT = 1'b1; CMPO = 1'b1;
    sb_q.push_back(8'hFF); sb_q.push_back(8'hFF);
    @(negedge CLK); START = 1'b1;
    @(posedge CLK); @(negedge CLK); START = 1'b0;
    wait_valid();
    check("bp_ovr_first", OVR, 0);
    wait_valid();
    check("bp_ovr_set", OVR, 1);
    CONT = 1'b0;
    @(posedge CLK); @(negedge CLK);
    check("bp_idle", BUSY, 0);
    check("bp_ovr_sticky", OVR, 1);
    CLR_OVR = 1'b1;
    @(posedge CLK); @(negedge CLK);
    CLR_OVR = 1'b0;
    check("bp_ovr_cleared", OVR, 0);
    check("bp_dv_held", DOUT_VALID, 1);
    DOUT_READY = 1'b1;
    @(posedge CLK); @(negedge CLK);
    check("bp_dv_accept", DOUT_VALID, 0);

    // Accept and load on the same edge.
    DOUT_READY = 1'b0; CONT = 1'b1; CMPO = 1'b0;
    sb_q.push_back(8'h00); sb_q.push_back(8'h00);
    @(negedge CLK); START = 1'b1;
    @(posedge CLK); @(negedge CLK); START = 1'b0;
    wait_valid();
    check("sim_dv_first", DOUT_VALID, 1);
    repeat (10) @(posedge CLK);
    @(negedge CLK); DOUT_READY = 1'b1; CONT = 1'b0;
    @(posedge CLK); @(negedge CLK);
    check("sim_valid", VALID, 1);
    check("sim_dv_kept", DOUT_VALID, 1);
    check("sim_no_ovr", OVR, 0);
    @(posedge CLK); @(negedge CLK);
    check("sim_dv_drop", DOUT_VALID, 0);
    check("sim_idle", BUSY, 0);

    // Reset in the middle of CONV after four bits.
    @(negedge CLK); START = 1'b1; CMPO = 1'b1;
    @(posedge CLK); @(negedge CLK); START = 1'b0;
    repeat (6) @(posedge CLK);
    @(negedge CLK);
    check("rst_partial", RESULTP, 8'hF0);
    RSTN = 1'b0;
    @(posedge CLK); @(negedge CLK);
    check_all_zero("midrst");
    RSTN = 1'b1;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("midrst_dv_low", DOUT_VALID, 0);
    sb_q.push_back(8'h3C);
    do_conv(8'h3C, 1'b0);

    // START noise during SAMP and CONV.
    nv0 = n_valid;
    sb_q.push_back(8'h6B);
    do_conv(8'h6B, 1'b1);
    repeat (12) @(posedge CLK);
    #1;
    check("noise_one_valid", n_valid - nv0, 1);
    check("noise_idle", BUSY, 0);

    // Continuous mode, CMPO=0, overrun set beats a held clear, CONT dropped in CONV.
    DOUT_READY = 1'b0; CLR_OVR = 1'b1; CONT = 1'b1; CMPO = 1'b0;
    sb_q.push_back(8'h00); sb_q.push_back(8'h00); sb_q.push_back(8'h00);
    @(negedge CLK); START = 1'b1;
    @(posedge CLK); @(negedge CLK); START = 1'b0;
    wait_valid(); t1 = cyc;
    check("cont_ovr_none", OVR, 0);
    wait_valid(); t2 = cyc;
    check("cont_period1", t2 - t1, 11);
    check("cont_ovr_setwins", OVR, 1);
    repeat (5) @(posedge CLK);
    @(negedge CLK); CONT = 1'b0;
    wait_valid(); t3 = cyc;
    check("cont_period2", t3 - t2, 11);
    @(posedge CLK); @(negedge CLK);
    check("cont_idle", BUSY, 0);
    check("cont_sample_low", SAMPLE, 0);
    CLR_OVR = 1'b0; DOUT_READY = 1'b1;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("sb_drained", sb_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
